// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bi one bit per cycle, LSB first,
// and presents the registered difference, borrow-out and signed overflow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             el,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_diff;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_acc_nxt;

    // One full-subtractor bit slice on the current LSBs and the running borrow.
    always_comb begin
        w_diff    = r_a[0] ^ r_b[0] ^ r_br;
        w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        w_acc_nxt = {w_diff, r_acc[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered status outputs;
    // el high freezes every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!el) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bi;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_nxt;
                    r_acc <= w_acc_nxt;
                    if (r_cnt == LAST_BIT) begin
                        // Last bit: publish results on the same edge it is computed.
                        r_d     <= w_acc_nxt;
                        r_bo    <= w_br_nxt;
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_acc_nxt[WIDTH-1] != r_a_msb);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign d    = r_d;
    assign bo   = r_bo;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule
